mix_dma_accelerator: RTL and testbench
======================================

# mix_dma_accelerator

Parametrised N-channel successor to the two-buffer stereo accelerator. It is configured through an Avalon-MM slave, then uses an Avalon-MM master to fetch one sample per channel from NUM_CH source buffers. For each sample index it applies a per-channel gain, sums the channels, saturates, and writes the mixed stream to an output buffer. It sits between the Nios/host slave fabric and the shared sample memory.

## Interface
- avs_avalonslave_data_width, 32, slave data width
- avs_avalonslave_address_width, 4, slave word-address width (register map below requires NUM_CH ≤ 4)
- avm_avalonmaster_data_width, 32, master data width
- avm_avalonmaster_address_width, 32, master address width
- NUM_CH, 2, number of input channels, 1..4
- LEN_W, 16, width of the per-run sample count
- GAIN_W, 8, unsigned per-channel gain width
- GAIN_FRAC, 6, gain fractional bits (gain 64 = 1.0)
- ADDR_STEP, 1, master address increment per sample
- csi_clock_clk  in  1  the single clock
- csi_clock_reset  in  1  synchronous, active-high reset
- avs_avalonslave_address  in  avs_avalonslave_address_width  register word address
- avs_avalonslave_read  in  1  register read strobe
- avs_avalonslave_write  in  1  register write strobe
- avs_avalonslave_writedata  in  32  register write data
- avs_avalonslave_readdata  out  32  register read data, combinational, 0 cycles of read latency
- avm_avalonmaster_address  out  32  memory address
- avm_avalonmaster_read  out  1  memory read request
- avm_avalonmaster_write  out  1  memory write request
- avm_avalonmaster_writedata  out  32  mixed sample, sign-extended
- avm_avalonmaster_waitrequest  in  1  stall; holds the current transfer
- avm_avalonmaster_readdata  in  32  sample; bits [15:0] are signed 16-bit
- DONE  out  1  run-complete flag, level

## Operation
- Register map (word address):
  - 0 CTRL: W bit0 GO, W bit1 ABORT, RW bits[LEN_W+15:16] LENGTH.
  - 1 OUT_ADDR.
  - 2 STATUS (RO): bit0 BUSY, bit1 DONE, bit2 ABORTED, bits[31:16] samples written.
  - 4+i CH_BASE[i].
  - 8+i CH_GAIN[i] (low GAIN_W bits).
  - Unmapped addresses and unused channel slots read as 0 and ignore writes.
- Registers are written only in IDLE. While the block is busy, only the ABORT bit of CTRL is honoured.
- A GO write in IDLE clears DONE, ABORTED and the sample count, loads the working pointers, and enters RD. With LENGTH=0 the block goes straight to DONE with no bus traffic.
- Per sample index k, channel order is 0..NUM_CH-1:
  - RD_i: read CH_BASE[i]+k·ADDR_STEP.
  - On acceptance, acc += sext(data[15:0]) × gain_i. The acc width is 16+GAIN_W+2 bits.
  - CALC: y = acc >>> GAIN_FRAC (arithmetic shift), then saturate to [-32768, 32767]. acc is cleared.
  - WR: write sext32(y) to OUT_ADDR+k·ADDR_STEP.
  - After acceptance, k++. If k==LENGTH, go to DONE, else go to RD_0.
- In DONE, the DONE output goes to 1 and STATUS.DONE goes to 1, and the FSM returns to IDLE. DONE holds until the next GO or reset.
- ABORT while busy: the block finishes any transfer in progress (it never drops read or write while waitrequest is high). It then returns to IDLE with ABORTED=1 and DONE=0. An ABORT write in IDLE has no effect.
- Reset, including mid-run: all registers and outputs go to 0 and the FSM goes to IDLE on the same edge.

## Timing
- Reset values are 0 for every output: readdata (address 0 → CTRL=0), master address, read, write, writedata, and DONE.
- A transfer is accepted on an edge where read or write is 1 and waitrequest is 0. Readdata is sampled on that same edge. Address, read, write and writedata stay stable while waitrequest is 1.
- A GO write is sampled at edge T. The first read is visible in the cycle after T.
- With no waitrequest, each sample takes NUM_CH+2 cycles: NUM_CH reads, 1 CALC, 1 write.
- read and write are never asserted together. Both are 0 in CALC, IDLE and DONE.
- DONE rises in the cycle after the last write is accepted.
- Total run time with no waitrequest is LENGTH·(NUM_CH+2)+1 cycles from the GO edge to DONE=1.
- STATUS reflects the state registered at the previous edge.

## Test plan
- Reset: hold csi_clock_reset for 2 cycles → all outputs 0, STATUS=0, DONE=0.
- Basic mix with NUM_CH=2, gains 64/64, LENGTH=4, CH_BASE=0x46/0x50, OUT=0x64, L=[100,200,-50,0], R=[1,2,3,-7]:
  - writes of [101,202,-47,-7] to 0x64..0x67;
  - read order 0x46,0x50,0x47,0x51…;
  - DONE=1 exactly 17 cycles after the GO edge.
- Gain and saturation: gains 32/128 with L=30000 and R=30000 → 32767 (0x00007FFF). With L=-30000 and R=-30000 → 0xFFFF8000. With L=3 and gain 32 (R gain 0) → 1.
- waitrequest held high for 3 cycles on every read and write → address, read, write and writedata stay stable; results are identical to the basic case; run time grows by 3 cycles per transfer.
- LENGTH=0 with GO → DONE=1 at GO+1; avm_avalonmaster_read and avm_avalonmaster_write never asserted.
- Control edge cases:
  - ABORT after 2 samples written → the in-flight transfer completes, then IDLE with STATUS.ABORTED=1, DONE=0, count=2.
  - GO while busy is ignored.
  - Reset asserted mid-read → read drops the next cycle and the FSM is in IDLE.

Source files
------------

// File: rtl/mix_dma_accelerator_if.sv
// Avalon-MM slave (register port) and master (sample memory port) of the mixing DMA.
// The slave modport is the accelerator side; master is the host/memory side.
interface mix_dma_accelerator_if #(
    parameter int unsigned avs_avalonslave_data_width     = 32,
    parameter int unsigned avs_avalonslave_address_width  = 4,
    parameter int unsigned avm_avalonmaster_data_width    = 32,
    parameter int unsigned avm_avalonmaster_address_width = 32
);
    logic [avs_avalonslave_address_width-1:0]  avs_avalonslave_address;
    logic                                      avs_avalonslave_read;
    logic                                      avs_avalonslave_write;
    logic [avs_avalonslave_data_width-1:0]     avs_avalonslave_writedata;
    logic [avs_avalonslave_data_width-1:0]     avs_avalonslave_readdata;

    logic [avm_avalonmaster_address_width-1:0] avm_avalonmaster_address;
    logic                                      avm_avalonmaster_read;
    logic                                      avm_avalonmaster_write;
    logic [avm_avalonmaster_data_width-1:0]    avm_avalonmaster_writedata;
    logic                                      avm_avalonmaster_waitrequest;
    logic [avm_avalonmaster_data_width-1:0]    avm_avalonmaster_readdata;

    modport slave (
        input  avs_avalonslave_address, avs_avalonslave_read, avs_avalonslave_write,
        input  avs_avalonslave_writedata,
        output avs_avalonslave_readdata,
        output avm_avalonmaster_address, avm_avalonmaster_read, avm_avalonmaster_write,
        output avm_avalonmaster_writedata,
        input  avm_avalonmaster_waitrequest, avm_avalonmaster_readdata
    );

    modport master (
        output avs_avalonslave_address, avs_avalonslave_read, avs_avalonslave_write,
        output avs_avalonslave_writedata,
        input  avs_avalonslave_readdata,
        input  avm_avalonmaster_address, avm_avalonmaster_read, avm_avalonmaster_write,
        input  avm_avalonmaster_writedata,
        output avm_avalonmaster_waitrequest, avm_avalonmaster_readdata
    );
endinterface

// File: rtl/mix_dma_accelerator.sv
// N-channel gain/mix DMA: fetches one sample per channel, scales, sums, saturates and
// writes the mixed stream back; configured through the Avalon-MM slave register map.
module mix_dma_accelerator #(
    parameter int unsigned avs_avalonslave_data_width     = 32,
    parameter int unsigned avs_avalonslave_address_width  = 4,
    parameter int unsigned avm_avalonmaster_data_width    = 32,
    parameter int unsigned avm_avalonmaster_address_width = 32,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned GAIN_W    = 8,
    parameter int unsigned GAIN_FRAC = 6,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic                 csi_clock_clk,
    input  logic                 csi_clock_reset,
    mix_dma_accelerator_if.slave bus,
    output logic                 DONE
);
    localparam int unsigned SAW   = avs_avalonslave_address_width;
    localparam int unsigned SDW   = avs_avalonslave_data_width;
    localparam int unsigned MAW   = avm_avalonmaster_address_width;
    localparam int unsigned MDW   = avm_avalonmaster_data_width;
    localparam int unsigned ACC_W = 16 + GAIN_W + 2;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_DONE} state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]  length;
    logic [LEN_W-1:0]  sample_cnt;
    logic [MAW-1:0]    out_addr;
    logic [MAW-1:0]    ch_base [NUM_CH];
    logic [GAIN_W-1:0] ch_gain [NUM_CH];
    logic [MAW-1:0]    rd_ptr  [NUM_CH];
    logic [MAW-1:0]    wr_ptr;
    logic [CH_W-1:0]   ch;
    logic signed [ACC_W-1:0] acc;
    logic [15:0]       y;
    logic              done_flag;
    logic              aborted;
    logic              abort_pend;

    logic [SAW-1:0]    addr;
    logic [SDW-1:0]    wd;
    logic [SDW-1:0]    rdata;
    logic              ctrl_wr, go, abort_wr, abort_now;
    logic              rd_acc, wr_acc, last_ch, last_sample, abort_exit;
    logic signed [ACC_W-1:0] samp_x, gain_x, prod, shifted;
    logic [15:0]       y_sat;
    logic              unused_rdata_hi;

    assign addr        = bus.avs_avalonslave_address;
    assign wd          = bus.avs_avalonslave_writedata;
    assign ctrl_wr     = bus.avs_avalonslave_write && (addr == SAW'(0));
    assign go          = (state == S_IDLE) && ctrl_wr && wd[0];
    assign abort_wr    = (state != S_IDLE) && ctrl_wr && wd[1];
    assign abort_now   = abort_pend || abort_wr;
    assign rd_acc      = (state == S_RD) && !bus.avm_avalonmaster_waitrequest;
    assign wr_acc      = (state == S_WR) && !bus.avm_avalonmaster_waitrequest;
    assign last_ch     = (ch == CH_W'(NUM_CH - 1));
    assign last_sample = ((sample_cnt + LEN_W'(1)) == length);
    // Abort only leaves at a transfer boundary so no request is dropped under waitrequest.
    assign abort_exit  = abort_now && ((state == S_CALC) || rd_acc || wr_acc);

    assign unused_rdata_hi = ^bus.avm_avalonmaster_readdata[MDW-1:16];

    always_comb begin
        samp_x  = {{(ACC_W-16){bus.avm_avalonmaster_readdata[15]}}, bus.avm_avalonmaster_readdata[15:0]};
        gain_x  = {{(ACC_W-GAIN_W){1'b0}}, ch_gain[ch]};
        prod    = samp_x * gain_x;
        shifted = acc >>> GAIN_FRAC;
        if ((&shifted[ACC_W-1:15]) || !(|shifted[ACC_W-1:15])) begin
            y_sat = shifted[15:0];
        end else begin
            y_sat = shifted[ACC_W-1] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (go) state_nxt = (wd[16 +: LEN_W] == '0) ? S_DONE : S_RD;
            S_RD: begin
                if (rd_acc) begin
                    if (abort_now)    state_nxt = S_IDLE;
                    else if (last_ch) state_nxt = S_CALC;
                end
            end
            S_CALC: state_nxt = abort_now ? S_IDLE : S_WR;
            S_WR: begin
                if (wr_acc) begin
                    if (abort_now)        state_nxt = S_IDLE;
                    else if (last_sample) state_nxt = S_DONE;
                    else                  state_nxt = S_RD;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.avm_avalonmaster_read  = (state == S_RD);
        bus.avm_avalonmaster_write = (state == S_WR);
        if (state == S_RD)      bus.avm_avalonmaster_address = rd_ptr[ch];
        else if (state == S_WR) bus.avm_avalonmaster_address = wr_ptr;
        else                    bus.avm_avalonmaster_address = '0;
        bus.avm_avalonmaster_writedata = {{(MDW-16){y[15]}}, y};
    end

    always_comb begin
        rdata = '0;
        if (bus.avs_avalonslave_read) begin
            if (addr == SAW'(0)) rdata[16 +: LEN_W] = length;
            if (addr == SAW'(1)) rdata[MAW-1:0] = out_addr;
            if (addr == SAW'(2)) begin
                rdata[31:16] = 16'(sample_cnt);
                rdata[2:0]   = {aborted, done_flag, (state != S_IDLE)};
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (addr == SAW'(4 + i)) rdata[MAW-1:0] = ch_base[i];
                if (addr == SAW'(8 + i)) rdata[GAIN_W-1:0] = ch_gain[i];
            end
        end
    end

    assign bus.avs_avalonslave_readdata = rdata;
    assign DONE = done_flag;

    always_ff @(posedge csi_clock_clk) begin
        if (csi_clock_reset) begin
            state      <= S_IDLE;
            length     <= '0;
            sample_cnt <= '0;
            out_addr   <= '0;
            wr_ptr     <= '0;
            ch         <= '0;
            acc        <= '0;
            y          <= '0;
            done_flag  <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ch_base[i] <= '0;
                ch_gain[i] <= '0;
                rd_ptr[i]  <= '0;
            end
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && bus.avs_avalonslave_write) begin
                if (addr == SAW'(0)) length <= wd[16 +: LEN_W];
                if (addr == SAW'(1)) out_addr <= wd[MAW-1:0];
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (addr == SAW'(4 + i)) ch_base[i] <= wd[MAW-1:0];
                    if (addr == SAW'(8 + i)) ch_gain[i] <= wd[GAIN_W-1:0];
                end
            end
            if (go) begin
                done_flag  <= 1'b0;
                aborted    <= 1'b0;
                abort_pend <= 1'b0;
                sample_cnt <= '0;
                ch         <= '0;
                acc        <= '0;
                wr_ptr     <= out_addr;
                for (int unsigned i = 0; i < NUM_CH; i++) rd_ptr[i] <= ch_base[i];
            end
            if (abort_wr) abort_pend <= 1'b1;
            if (rd_acc) begin
                acc <= acc + prod;
                ch  <= last_ch ? '0 : ch + CH_W'(1);
            end
            if (state == S_CALC) begin
                y   <= y_sat;
                acc <= '0;
            end
            if (wr_acc) begin
                sample_cnt <= sample_cnt + LEN_W'(1);
                wr_ptr     <= wr_ptr + MAW'(ADDR_STEP);
                for (int unsigned i = 0; i < NUM_CH; i++) rd_ptr[i] <= rd_ptr[i] + MAW'(ADDR_STEP);
            end
            if (abort_exit) begin
                aborted    <= 1'b1;
                abort_pend <= 1'b0;
                ch         <= '0;
            end
            if (state == S_DONE) begin
                done_flag  <= 1'b1;
                abort_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mix_dma_accelerator.sv
// Scoreboarded bench for mix_dma_accelerator: expected master reads/writes are queued by
// the stimulus; a memory monitor answers the master port and checks every accepted transfer.
module tb_mix_dma_accelerator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic DONE;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mix_dma_accelerator_if bus ();

    mix_dma_accelerator #(
        .NUM_CH(2), .LEN_W(16), .GAIN_W(8), .GAIN_FRAC(6), .ADDR_STEP(1)
    ) dut (
        .csi_clock_clk  (clk),
        .csi_clock_reset(rst),
        .bus            (bus),
        .DONE           (DONE)
    );

    logic [31:0] mem [0:255];
    logic [31:0] exp_rd [$];
    logic [63:0] exp_wr [$];
    int n_vec = 0, n_miss = 0;
    int wait_n = 0, wr_seen = 0, req_cnt = 0;
    logic [31:0] rv;
    int gc, dummy, r0, w0;

    int L [4] = '{100, 200, -50, 0};
    int R [4] = '{1, 2, 3, -7};
    int Y [4] = '{101, 202, -47, -7};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d, output int edge_c);
        bus.avs_avalonslave_address   = a;
        bus.avs_avalonslave_writedata = d;
        bus.avs_avalonslave_write     = 1'b1;
        @(posedge clk);
        #1;
        edge_c = cyc;
        bus.avs_avalonslave_write = 1'b0;
        #1;
    endtask

    task automatic reg_rd(input logic [3:0] a, output logic [31:0] v);
        bus.avs_avalonslave_address = a;
        bus.avs_avalonslave_read    = 1'b1;
        #1;
        v = bus.avs_avalonslave_readdata;
        bus.avs_avalonslave_read = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int go_c, input int exp_cyc, input string nm);
        for (int i = 0; i < 400 && !DONE; i++) tick();
        check({nm, "_done"}, 32'(DONE), 32'd1);
        check({nm, "_cycles"}, 32'(cyc - go_c), 32'(exp_cyc));
    endtask

    task automatic check_drained(input string nm);
        check({nm, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
        check({nm, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic load_basic();
        for (int k = 0; k < 4; k++) begin
            mem[8'h46 + k] = {16'hA5A5, 16'(L[k])};
            mem[8'h50 + k] = {16'h5A5A, 16'(R[k])};
        end
    endtask

    task automatic push_basic(input int n_wr, input int n_rd);
        for (int k = 0; k < 4; k++) begin
            if (2 * k < n_rd)     exp_rd.push_back(32'h46 + k);
            if (2 * k + 1 < n_rd) exp_rd.push_back(32'h50 + k);
            if (k < n_wr)         exp_wr.push_back({32'h64 + k, 32'(Y[k])});
        end
    endtask

    task automatic sat_run(input logic [15:0] l, input logic [15:0] r, input logic [7:0] g0,
                           input logic [7:0] g1, input logic [31:0] y_exp, input string nm);
        int g;
        mem[8'h46] = {16'h0000, l};
        mem[8'h50] = {16'hFFFF, r};
        reg_wr(4'd8, {24'd0, g0}, dummy);
        reg_wr(4'd9, {24'd0, g1}, dummy);
        exp_rd.push_back(32'h46);
        exp_rd.push_back(32'h50);
        exp_wr.push_back({32'h64, y_exp});
        reg_wr(4'd0, {16'd1, 16'd1}, g);
        wait_done(g, 5, nm);
        check_drained(nm);
    endtask

    initial begin
        bus.avs_avalonslave_address      = '0;
        bus.avs_avalonslave_read         = 1'b0;
        bus.avs_avalonslave_write        = 1'b0;
        bus.avs_avalonslave_writedata    = '0;
        bus.avm_avalonmaster_waitrequest = 1'b0;
        bus.avm_avalonmaster_readdata    = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | 32'(i);
        fork
            begin : monitor
                int stall;
                logic [31:0] h_addr, h_wd, a, d;
                logic [1:0]  h_ctl;
                logic [63:0] e;
                stall = 0;
                forever begin
                    @(negedge clk);
                    if (rst || !(bus.avm_avalonmaster_read || bus.avm_avalonmaster_write)) begin
                        bus.avm_avalonmaster_waitrequest = 1'b0;
                        stall = 0;
                    end else begin
                        a = bus.avm_avalonmaster_address;
                        d = bus.avm_avalonmaster_writedata;
                        req_cnt++;
                        check("rd_wr_exclusive",
                              32'(bus.avm_avalonmaster_read && bus.avm_avalonmaster_write), 32'd0);
                        if (stall == 0) begin
                            h_addr = a;
                            h_wd   = d;
                            h_ctl  = {bus.avm_avalonmaster_read, bus.avm_avalonmaster_write};
                        end else begin
                            check("hold_addr", a, h_addr);
                            check("hold_ctl", 32'({bus.avm_avalonmaster_read, bus.avm_avalonmaster_write}),
                                  32'(h_ctl));
                            check("hold_wdata", d, h_wd);
                        end
                        if (stall < wait_n) begin
                            bus.avm_avalonmaster_waitrequest = 1'b1;
                            bus.avm_avalonmaster_readdata    = 32'hBAD0BAD0;
                            stall++;
                        end else begin
                            bus.avm_avalonmaster_waitrequest = 1'b0;
                            stall = 0;
                            if (bus.avm_avalonmaster_read) begin
                                bus.avm_avalonmaster_readdata = mem[a[7:0]];
                                if (exp_rd.size() == 0) begin
                                    n_vec++;
                                    n_miss++;
                                    $display("FAIL rd_unexpected: got read of %h, expected none", a);
                                end else begin
                                    check("rd_addr", a, exp_rd.pop_front());
                                end
                            end else begin
                                wr_seen++;
                                if (exp_wr.size() == 0) begin
                                    n_vec++;
                                    n_miss++;
                                    $display("FAIL wr_unexpected: got write %h to %h, expected none", d, a);
                                end else begin
                                    e = exp_wr.pop_front();
                                    check("wr_addr", a, e[63:32]);
                                    check("wr_data", d, e[31:0]);
                                end
                            end
                        end
                    end
                end
            end
            begin : stimulus
                // reset held for two edges
                @(posedge clk);
                tick();
                check("rst_done", 32'(DONE), 32'd0);
                check("rst_addr", bus.avm_avalonmaster_address, 32'd0);
                check("rst_read", 32'(bus.avm_avalonmaster_read), 32'd0);
                check("rst_write", 32'(bus.avm_avalonmaster_write), 32'd0);
                check("rst_wdata", bus.avm_avalonmaster_writedata, 32'd0);
                check("rst_rdata", bus.avs_avalonslave_readdata, 32'd0);
                rst = 1'b0;
                tick();
                reg_rd(4'd0, rv); check("rst_ctrl", rv, 32'd0);
                reg_rd(4'd2, rv); check("rst_status", rv, 32'd0);

                // basic two-channel mix at unity gain
                load_basic();
                reg_wr(4'd4, 32'h46, dummy);
                reg_wr(4'd5, 32'h50, dummy);
                reg_wr(4'd8, 32'd64, dummy);
                reg_wr(4'd9, 32'd64, dummy);
                reg_wr(4'd1, 32'h64, dummy);
                reg_wr(4'd6, 32'h1234, dummy);
                reg_wr(4'd3, 32'h5678, dummy);
                push_basic(4, 8);
                reg_wr(4'd0, {16'd4, 16'd1}, gc);
                wait_done(gc, 17, "basic");
                check_drained("basic");
                reg_rd(4'd2, rv); check("basic_status", rv, 32'h0004_0002);
                reg_rd(4'd0, rv); check("basic_ctrl", rv, 32'h0004_0000);
                reg_rd(4'd4, rv); check("base0_rb", rv, 32'h46);
                reg_rd(4'd9, rv); check("gain1_rb", rv, 32'd64);
                reg_rd(4'd6, rv); check("unused_slot", rv, 32'd0);
                reg_rd(4'd3, rv); check("unmapped", rv, 32'd0);

                // gain and saturation
                sat_run(16'd30000, 16'd30000, 8'd32, 8'd128, 32'h0000_7FFF, "sat_pos");
                sat_run(16'h8AD0, 16'h8AD0, 8'd32, 8'd128, 32'hFFFF_8000, "sat_neg");
                sat_run(16'd3, 16'd1000, 8'd32, 8'd0, 32'h0000_0001, "half_gain");

                // waitrequest of 3 cycles on every transfer
                load_basic();
                reg_wr(4'd8, 32'd64, dummy);
                reg_wr(4'd9, 32'd64, dummy);
                wait_n = 3;
                push_basic(4, 8);
                reg_wr(4'd0, {16'd4, 16'd1}, gc);
                wait_done(gc, 53, "waitreq");
                check_drained("waitreq");
                wait_n = 0;

                // zero-length run
                r0 = req_cnt;
                reg_wr(4'd0, {16'd0, 16'd1}, gc);
                wait_done(gc, 1, "len0");
                repeat (3) tick();
                check("len0_no_bus", 32'(req_cnt - r0), 32'd0);
                reg_rd(4'd2, rv); check("len0_status", rv, 32'h0000_0002);

                // GO while busy is ignored, including its LENGTH field
                push_basic(4, 8);
                reg_wr(4'd0, {16'd4, 16'd1}, gc);
                repeat (5) tick();
                reg_wr(4'd0, {16'd1, 16'd1}, dummy);
                wait_done(gc, 17, "go_busy");
                check_drained("go_busy");
                reg_rd(4'd0, rv); check("go_busy_len", rv, 32'h0004_0000);

                // abort after two samples written
                push_basic(2, 5);
                w0 = wr_seen;
                reg_wr(4'd0, {16'd4, 16'd1}, gc);
                for (int i = 0; i < 100 && wr_seen < w0 + 2; i++) tick();
                check("abort_wait", 32'(wr_seen - w0), 32'd2);
                reg_wr(4'd0, 32'h0000_0002, dummy);
                repeat (4) tick();
                check_drained("abort");
                check("abort_done", 32'(DONE), 32'd0);
                check("abort_read", 32'(bus.avm_avalonmaster_read), 32'd0);
                reg_rd(4'd2, rv); check("abort_status", rv, 32'h0002_0004);
                reg_wr(4'd0, {16'd4, 16'd2}, dummy);
                reg_rd(4'd2, rv); check("idle_abort_noop", rv, 32'h0002_0004);

                // reset asserted while a read is stalled
                wait_n = 10;
                reg_wr(4'd0, {16'd4, 16'd1}, gc);
                check("midrd_active", 32'(bus.avm_avalonmaster_read), 32'd1);
                rst = 1'b1;
                tick();
                check("midrd_read", 32'(bus.avm_avalonmaster_read), 32'd0);
                check("midrd_write", 32'(bus.avm_avalonmaster_write), 32'd0);
                check("midrd_done", 32'(DONE), 32'd0);
                reg_rd(4'd2, rv); check("midrd_status", rv, 32'd0);
                reg_rd(4'd4, rv); check("midrd_base", rv, 32'd0);
                rst = 1'b0;
                wait_n = 0;
                repeat (3) tick();
                check_drained("midrd");
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
